glue_cycle_ctrl: RTL and testbench

//  Parametrised 68010/68030 bus-cycle controller for the rosco glue CPLD.
//  - Decodes addresses into chip selects and applies a sticky BOOT ROM overlay.
//  - Generates DTACK with per-region wait states and a bus-error watchdog.
//  - Optionally generates a 6800-style E clock.
//  - Sits between the CPU bus pins and the memory/IO selects; top-level tri-state pads wrap dtack_n/berr_n.

---
 rtl/glue_cycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_glue_cycle_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/glue_cycle_ctrl.sv
// glue_cycle_ctrl: 68010/68030 bus-cycle controller for the rosco glue CPLD.
// Address decode, sticky boot overlay, DTACK wait states, BERR watchdog; E clock when GLUE_ECLK_EN is defined.
module glue_cycle_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned ROM_WS      = 2,
  parameter int unsigned RAM_WS      = 0,
  parameter int unsigned EXP_WS      = 1,
  parameter int unsigned WD_CYCLES   = 128,
  parameter int unsigned E_DIV       = 10
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ASn,
  input  logic        DSn,
  input  logic        RW,
  input  logic [1:0]  SIZ,
  input  logic [2:0]  FC,
  input  logic [23:0] A,
  input  logic        io_dtack_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic [1:0]  rom_sel_n,
  output logic [1:0]  ram_sel_n,
  output logic        exp_sel_n,
  output logic        io_sel_n,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        boot,
  output logic        iack_n
`ifdef GLUE_ECLK_EN
  ,
  output logic        E
`endif
);

  localparam int unsigned WS_MAX0 = (ROM_WS > RAM_WS) ? ROM_WS : RAM_WS;
  localparam int unsigned WS_MAX  = (WS_MAX0 > EXP_WS) ? WS_MAX0 : EXP_WS;
  localparam int unsigned WS_W    = (WS_MAX < 1) ? 1 : $clog2(WS_MAX + 1);
  localparam int unsigned WD_W    = $clog2(WD_CYCLES);
  localparam int unsigned BC_W    = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_EXT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WS_W-1:0]   r_ws, w_ws_nxt, w_reg_ws;
  logic [WD_W-1:0]   r_wd, w_wd_nxt;
  logic [BC_W-1:0]   r_boot_cnt, w_boot_cnt_nxt;
  logic              r_asn_q;
  logic              r_dtack_n, w_dtack_n_nxt;
  logic              r_berr_n, w_berr_n_nxt;
  logic              r_boot, w_boot_nxt;

  logic [3:0] w_bank;
  logic       w_cpu, w_uds, w_lds, w_as;
  logic       w_rom_reg, w_ram_reg, w_io_reg, w_exp_reg;
  logic       w_wd_count;
  logic       w_unused;

  // Address decode; the overlay maps ROM into bank 0 until boot completes
  assign w_bank    = A[23:20];
  assign w_cpu     = (FC == 3'b111);
  assign w_uds     = !DSn && !A[0];
  assign w_lds     = !DSn && (A[0] || !SIZ[0] || SIZ[1]);
  assign w_rom_reg = (w_bank == 4'hE) || (!r_boot && (w_bank == 4'h0));
  assign w_ram_reg = r_boot && (w_bank == 4'h0);
  assign w_io_reg  = (w_bank == 4'hF);
  assign w_exp_reg = !w_rom_reg && !w_ram_reg && !w_io_reg;
  assign w_as      = !ASn && !w_cpu;

  assign uds_n     = !w_uds;
  assign lds_n     = !w_lds;
  assign rom_sel_n = ~{w_as && w_rom_reg && w_uds, w_as && w_rom_reg && w_lds};
  assign ram_sel_n = ~{w_as && w_ram_reg && w_uds, w_as && w_ram_reg && w_lds};
  assign exp_sel_n = !(w_as && w_exp_reg);
  assign io_sel_n  = !(w_io_reg && !w_cpu);
  assign iack_n    = !(w_cpu && !ASn && A[19] && (A[3:1] == 3'b100));

  assign w_reg_ws  = w_rom_reg ? WS_W'(ROM_WS) :
                     w_ram_reg ? WS_W'(RAM_WS) : WS_W'(EXP_WS);

  assign w_wd_count = !r_asn_q && r_dtack_n && io_dtack_n;
  assign w_unused   = ^{RW, A[18:4]};

  assign dtack_n = r_dtack_n;
  assign berr_n  = r_berr_n;
  assign boot    = r_boot;

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state    <= ST_IDLE;
      r_ws       <= '0;
      r_wd       <= '0;
      r_boot_cnt <= '0;
      r_asn_q    <= 1'b1;
      r_dtack_n  <= 1'b1;
      r_berr_n   <= 1'b1;
      r_boot     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ws       <= w_ws_nxt;
      r_wd       <= w_wd_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_asn_q    <= ASn;
      r_dtack_n  <= w_dtack_n_nxt;
      r_berr_n   <= w_berr_n_nxt;
      r_boot     <= w_boot_nxt;
    end
  end

  // Next-state: ASn is the value asn_q takes on this edge, so a high strobe ends the cycle here
  always_comb begin
    w_state_nxt    = r_state;
    w_ws_nxt       = r_ws;
    w_wd_nxt       = r_wd;
    w_berr_n_nxt   = r_berr_n;
    w_boot_cnt_nxt = r_boot_cnt;
    w_boot_nxt     = r_boot;

    if (ASn) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_asn_q && !w_cpu) begin
            if (w_io_reg) begin
              w_state_nxt = ST_EXT;
            end else if (w_reg_ws == '0) begin
              w_state_nxt = ST_ACK;
            end else begin
              w_state_nxt = ST_WAIT;
              w_ws_nxt    = w_reg_ws;
            end
          end
        end
        ST_WAIT: begin
          if (r_ws <= WS_W'(1)) begin
            w_state_nxt = ST_ACK;
            w_ws_nxt    = '0;
          end else begin
            w_ws_nxt = r_ws - WS_W'(1);
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end

    w_dtack_n_nxt = (w_state_nxt != ST_ACK);

    // Watchdog saturates at WD_CYCLES-1; a simultaneous DTACK suppresses BERR
    if (ASn) begin
      w_wd_nxt     = '0;
      w_berr_n_nxt = 1'b1;
    end else if (w_wd_count && r_berr_n) begin
      if (r_wd == WD_W'(WD_CYCLES - 2)) begin
        w_wd_nxt     = WD_W'(WD_CYCLES - 1);
        w_berr_n_nxt = !w_dtack_n_nxt;
      end else if (r_wd != WD_W'(WD_CYCLES - 1)) begin
        w_wd_nxt = r_wd + WD_W'(1);
      end
    end

    if (!r_asn_q && ASn && (r_boot_cnt != BC_W'(BOOT_CYCLES))) begin
      w_boot_cnt_nxt = r_boot_cnt + BC_W'(1);
      if (r_boot_cnt == BC_W'(BOOT_CYCLES - 1)) begin
        w_boot_nxt = 1'b1;
      end
    end
  end

`ifdef GLUE_ECLK_EN
  localparam int unsigned E_W   = (E_DIV < 2) ? 1 : $clog2(E_DIV);
  localparam int unsigned E_LOW = E_DIV * 6 / 10;

  logic [E_W-1:0] r_ecnt, w_ecnt_nxt;
  logic           r_e;

  assign w_ecnt_nxt = (r_ecnt == E_W'(E_DIV - 1)) ? '0 : r_ecnt + E_W'(1);
  assign E          = r_e;

  // Free-running E divider: low for the first 60% of the period
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_ecnt <= '0;
      r_e    <= 1'b0;
    end else begin
      r_ecnt <= w_ecnt_nxt;
      r_e    <= (w_ecnt_nxt >= E_W'(E_LOW));
    end
  end
`else
  logic w_unused_ediv;
  assign w_unused_ediv = (E_DIV != 0);
`endif

endmodule

// File: tb/tb_glue_cycle_ctrl.sv
// Scoreboard bench for glue_cycle_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_glue_cycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        ASn, DSn, RW;
  logic [1:0]  SIZ;
  logic [2:0]  FC;
  logic [23:0] A;
  logic        io_dtack_n;
  logic        uds_n, lds_n, exp_sel_n, io_sel_n, dtack_n, berr_n, boot, iack_n;
  logic [1:0]  rom_sel_n, ram_sel_n;
`ifdef GLUE_ECLK_EN
  logic        E;
`endif

  glue_cycle_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .DSn(DSn), .RW(RW), .SIZ(SIZ), .FC(FC), .A(A),
    .io_dtack_n(io_dtack_n), .uds_n(uds_n), .lds_n(lds_n), .rom_sel_n(rom_sel_n),
    .ram_sel_n(ram_sel_n), .exp_sel_n(exp_sel_n), .io_sel_n(io_sel_n), .dtack_n(dtack_n),
    .berr_n(berr_n), .boot(boot), .iack_n(iack_n)
`ifdef GLUE_ECLK_EN
    , .E(E)
`endif
  );

  always #5 CLK = ~CLK;

  localparam int S_DTACK = 0, S_BERR = 1, S_BOOT = 2, S_ROM = 3, S_RAM = 4, S_IO = 5,
                 S_EXP = 6, S_UDS = 7, S_LDS = 8, S_IACK = 9, S_E = 10;

  typedef struct {
    int         cyc;
    int         sig;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_DTACK: return "dtack_n";
      S_BERR:  return "berr_n";
      S_BOOT:  return "boot";
      S_ROM:   return "rom_sel_n";
      S_RAM:   return "ram_sel_n";
      S_IO:    return "io_sel_n";
      S_EXP:   return "exp_sel_n";
      S_UDS:   return "uds_n";
      S_LDS:   return "lds_n";
      S_IACK:  return "iack_n";
      default: return "E";
    endcase
  endfunction

  function automatic logic [1:0] actual(input int s);
    case (s)
      S_DTACK: return {1'b0, dtack_n};
      S_BERR:  return {1'b0, berr_n};
      S_BOOT:  return {1'b0, boot};
      S_ROM:   return rom_sel_n;
      S_RAM:   return ram_sel_n;
      S_IO:    return {1'b0, io_sel_n};
      S_EXP:   return {1'b0, exp_sel_n};
      S_UDS:   return {1'b0, uds_n};
      S_LDS:   return {1'b0, lds_n};
      S_IACK:  return {1'b0, iack_n};
`ifdef GLUE_ECLK_EN
      S_E:     return {1'b0, E};
`endif
      default: return 2'bxx;
    endcase
  endfunction

  // Monitor: every expectation due at this edge count is popped and compared
  always @(negedge CLK) begin
    logic [1:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].sig);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s at edge %0d: got %b expected %b",
                   sig_name(sb[i].sig), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int s, input logic [1:0] v);
    sb.push_back('{cyc: c, sig: s, val: v});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // One CPU cycle: strobes low now, held for 'hold' edges; io_dtack_n pulled low after edge io_ack_at
  task automatic as_cycle(input logic [23:0] addr, input logic [2:0] fc, input logic [1:0] siz,
                          input int hold, input int io_ack_at);
    A = addr; FC = fc; SIZ = siz; RW = 1'b1; ASn = 1'b0; DSn = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      tick(1);
      if (i == io_ack_at) io_dtack_n = 1'b0;
    end
    ASn = 1'b1; DSn = 1'b1; io_dtack_n = 1'b1;
    tick(3);
  endtask

  initial begin
    int e0;
    RESETn = 1'b0; ASn = 1'b1; DSn = 1'b1; RW = 1'b1; SIZ = 2'b10; FC = 3'b101;
    A = 24'h000000; io_dtack_n = 1'b1;
    tick(3);

    // Reset state
    e0 = cyc;
    push(e0, S_DTACK, 2'd1); push(e0, S_BERR, 2'd1); push(e0, S_BOOT, 2'd0);
    push(e0, S_IACK, 2'd1);  push(e0, S_ROM, 2'b11); push(e0, S_RAM, 2'b11);
    push(e0, S_EXP, 2'd1);   push(e0, S_IO, 2'd1);   push(e0, S_UDS, 2'd1);
`ifdef GLUE_ECLK_EN
    push(e0, S_E, 2'd0);
`endif
    tick(1);
    RESETn = 1'b1;
    tick(2);

    // Boot overlay: four ROM cycles at $000000, boot rises on the 4th ASn rise
    for (int i = 1; i <= 4; i++) begin
      e0 = cyc;
      push(e0, S_ROM, 2'b00); push(e0, S_RAM, 2'b11);
      push(e0 + 3, S_DTACK, 2'd1); push(e0 + 4, S_DTACK, 2'd0);
      push(e0 + 5, S_BOOT, 2'd0);
      push(e0 + 6, S_BOOT, (i == 4) ? 2'd1 : 2'd0);
      push(e0 + 6, S_DTACK, 2'd1);
      as_cycle(24'h000000, 3'b101, 2'b10, 5, 0);
    end

    checks++;
    if (boot !== 1'b1) begin
      errors++;
      $display("FAIL boot not set after four boot cycles: got %b", boot);
    end

    // 5th cycle at $000000 now hits RAM with zero wait states
    e0 = cyc;
    push(e0, S_RAM, 2'b00); push(e0, S_ROM, 2'b11);
    push(e0 + 1, S_DTACK, 2'd1); push(e0 + 2, S_DTACK, 2'd0);
    as_cycle(24'h000000, 3'b101, 2'b10, 4, 0);

    // ROM word read at $E00010: DTACK after 4 edges, released the edge after ASn rises
    e0 = cyc;
    push(e0, S_ROM, 2'b00);
    push(e0 + 3, S_DTACK, 2'd1); push(e0 + 4, S_DTACK, 2'd0);
    push(e0 + 6, S_DTACK, 2'd0); push(e0 + 7, S_DTACK, 2'd1);
    as_cycle(24'hE00010, 3'b101, 2'b10, 6, 0);

    // IO byte read at $F00001 answered by io_dtack_n at edge 5
    e0 = cyc;
    push(e0, S_IO, 2'd0); push(e0, S_LDS, 2'd0); push(e0, S_UDS, 2'd1); push(e0, S_ROM, 2'b11);
    push(e0 + 5, S_DTACK, 2'd1); push(e0 + 8, S_DTACK, 2'd1); push(e0 + 8, S_BERR, 2'd1);
    as_cycle(24'hF00001, 3'b101, 2'b01, 8, 4);

    // Expansion word read at $100000 with one wait state
    e0 = cyc;
    push(e0, S_EXP, 2'd0); push(e0, S_ROM, 2'b11); push(e0, S_RAM, 2'b11);
    push(e0 + 2, S_DTACK, 2'd1); push(e0 + 3, S_DTACK, 2'd0); push(e0 + 5, S_DTACK, 2'd1);
    as_cycle(24'h100000, 3'b101, 2'b10, 4, 0);

    // Interrupt acknowledge in CPU space: no selects, no DTACK
    e0 = cyc;
    push(e0, S_IACK, 2'd0); push(e0, S_ROM, 2'b11); push(e0, S_RAM, 2'b11);
    push(e0, S_EXP, 2'd1);  push(e0, S_IO, 2'd1);
    push(e0 + 3, S_DTACK, 2'd1); push(e0 + 4, S_IACK, 2'd1); push(e0 + 4, S_BERR, 2'd1);
    as_cycle(24'h080008, 3'b111, 2'b01, 4, 0);

    // Unanswered IO read: BERR at edge 128, cleared the edge after ASn rises
    e0 = cyc;
    push(e0 + 127, S_BERR, 2'd1); push(e0 + 128, S_BERR, 2'd0); push(e0 + 128, S_DTACK, 2'd1);
    push(e0 + 130, S_BERR, 2'd0); push(e0 + 131, S_BERR, 2'd1);
    as_cycle(24'hF00000, 3'b101, 2'b10, 130, 0);

    // Reset while a ROM cycle sits in WAIT, then the cycle restarts from the strobe
    e0 = cyc;
    push(e0 + 2, S_DTACK, 2'd1); push(e0 + 2, S_BOOT, 2'd1);
    push(e0 + 3, S_DTACK, 2'd1); push(e0 + 3, S_BERR, 2'd1); push(e0 + 3, S_BOOT, 2'd0);
    push(e0 + 4, S_DTACK, 2'd1); push(e0 + 6, S_DTACK, 2'd1); push(e0 + 7, S_DTACK, 2'd0);
    push(e0 + 9, S_DTACK, 2'd1);
`ifdef GLUE_ECLK_EN
    for (int k = 0; k < 20; k++) push(e0 + 3 + k, S_E, ((k % 10) >= 6) ? 2'd1 : 2'd0);
`endif
    A = 24'hE00000; FC = 3'b101; SIZ = 2'b10; ASn = 1'b0; DSn = 1'b0;
    tick(2);
    RESETn = 1'b0;
    tick(1);
    RESETn = 1'b1;
    tick(5);
    ASn = 1'b1; DSn = 1'b1;
    tick(16);

    tick(5);

    checks++;
    if (boot !== 1'b0) begin
      errors++;
      $display("FAIL boot set after reset with a single cycle: got %b", boot);
    end
    checks++;
    if (dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL dtack_n not idle at end: got %b", dtack_n);
    end
    checks++;
    if (berr_n !== 1'b1) begin
      errors++;
      $display("FAIL berr_n not idle at end: got %b", berr_n);
    end

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s expectation for edge %0d never checked (edge now %0d)",
               sig_name(sb[i].sig), sb[i].cyc, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
